button_debounce: RTL and testbench



---
 rtl/pet_input_pkg.sv | 17 +
 rtl/debounce_counter.sv | 40 ++++
 rtl/button_debounce.sv | 139 +++++++++++++
 tb/tb_button_debounce.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pet_input_pkg.sv
// Shared types and clock-derived defaults
// for the button/switch input path.
package pet_input_pkg;

  localparam int unsigned SYS_CLK_HZ = 64_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_5MS = SYS_CLK_HZ / 200;
  localparam int unsigned LONG_CYCLES_1S = SYS_CLK_HZ;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    LONG_HELD,
    RELEASE_PENDING
  } debounce_state_t;

endpackage

// File: rtl/debounce_counter.sv
// Saturating up-counter with synchronous clear;
// done_o flags the terminal count CYCLES-1.
module debounce_counter
  import pet_input_pkg::*;
#(
  parameter int unsigned CYCLES = 4
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic done_o
);

  localparam int unsigned W = $clog2(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign done_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !done_o) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces a synchronized button level into a clean
// level plus one-cycle press/release/long-press pulses.
module button_debounce
  import pet_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_5MS,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_1S,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic data_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  debounce_state_t state_q, state_d;
  logic was_long_q, was_long_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;

  logic pressed;
  logic d_clear, d_en, d_done;
  logic l_clear, l_en, l_done;

  assign pressed = data_i ^ ACTIVE_LOW;

  // dcount runs only while a transition is pending
  assign d_en    = (state_q == PRESS_PENDING) ||
                   (state_q == RELEASE_PENDING);
  assign d_clear = !d_en;

  // lcount survives release bounces; it restarts
  // only on a fresh press
  assign l_clear = !((state_q == PRESSED) ||
                     (state_q == LONG_HELD) ||
                     (state_q == RELEASE_PENDING));
  assign l_en    = (state_q == PRESSED) && pressed;

  debounce_counter #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_dcount (
    .clock_i (clock_i),
    .reset_ni(reset_ni),
    .clear_i (d_clear),
    .enable_i(d_en),
    .done_o  (d_done)
  );

  debounce_counter #(
    .CYCLES(LONG_CYCLES)
  ) u_lcount (
    .clock_i (clock_i),
    .reset_ni(reset_ni),
    .clear_i (l_clear),
    .enable_i(l_en),
    .done_o  (l_done)
  );

  always_comb begin
    state_d    = state_q;
    was_long_d = was_long_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (pressed) state_d = PRESS_PENDING;
      end
      PRESS_PENDING: begin
        if (!pressed) begin
          state_d = RELEASED;
        end else if (d_done) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d    = RELEASE_PENDING;
          was_long_d = 1'b0;
        end else if (l_done) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!pressed) begin
          state_d    = RELEASE_PENDING;
          was_long_d = 1'b1;
        end
      end
      RELEASE_PENDING: begin
        if (pressed) begin
          state_d = was_long_q ? LONG_HELD : PRESSED;
        end else if (d_done) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end
      end
      default: begin
        state_d    = RELEASED;
        was_long_d = 1'b0;
        level_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= RELEASED;
      was_long_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      was_long_q <= was_long_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with small
// cycle counts, both input polarities.
module tb_button_debounce;

  logic clk;
  logic rst_a, rst_b;
  logic a_data, a_level, a_press, a_rel, a_long;
  logic b_data, b_level, b_press, b_rel, b_long;
  int   passed;
  int   total;
  logic mutex_bad;
  logic any_long;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .ACTIVE_LOW     (1'b1)
  ) dut_a (
    .clock_i  (clk),
    .reset_ni (rst_a),
    .data_i   (a_data),
    .level_o  (a_level),
    .press_o  (a_press),
    .release_o(a_rel),
    .long_o   (a_long)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .ACTIVE_LOW     (1'b0)
  ) dut_b (
    .clock_i  (clk),
    .reset_ni (rst_b),
    .data_i   (b_data),
    .level_o  (b_level),
    .press_o  (b_press),
    .release_o(b_rel),
    .long_o   (b_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial mutex_bad = 1'b0;
  always @(negedge clk) begin
    if (!$onehot0({a_press, a_rel, a_long})) mutex_bad = 1'b1;
    if (!$onehot0({b_press, b_rel, b_long})) mutex_bad = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    a_data = 1'b1;
    b_data = 1'b0;

    #2;
    chk("rst_level", a_level, 1'b0);
    chk("rst_press", a_press, 1'b0);
    step(2);
    chk("rst_rel", a_rel, 1'b0);
    chk("rst_long", a_long, 1'b0);
    chk("rst_b_level", b_level, 1'b0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(2);

    // 1: three-clock glitch is rejected
    a_data = 1'b0;
    step(3);
    a_data = 1'b1;
    chk("glitch_level", a_level, 1'b0);
    chk("glitch_press", a_press, 1'b0);
    step(6);
    chk("glitch_level2", a_level, 1'b0);
    chk("glitch_press2", a_press, 1'b0);

    // 2: clean press, E0 is the first step
    a_data = 1'b0;
    step(4);
    chk("press_e3_level", a_level, 1'b0);
    chk("press_e3_press", a_press, 1'b0);
    step(1);
    chk("press_e4_level", a_level, 1'b1);
    chk("press_e4_press", a_press, 1'b1);
    step(1);
    chk("press_e5_press", a_press, 1'b0);
    chk("press_e5_level", a_level, 1'b1);

    // 3: long press at E0+14, once only
    step(8);
    chk("long_e13", a_long, 1'b0);
    step(1);
    chk("long_e14", a_long, 1'b1);
    step(1);
    chk("long_e15", a_long, 1'b0);
    any_long = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      any_long = any_long | a_long;
    end
    chk("long_once", any_long, 1'b0);
    a_data = 1'b1;
    step(4);
    chk("lrel_e3_rel", a_rel, 1'b0);
    chk("lrel_e3_level", a_level, 1'b1);
    step(1);
    chk("lrel_e4_rel", a_rel, 1'b1);
    chk("lrel_e4_level", a_level, 1'b0);
    step(1);
    chk("lrel_e5_rel", a_rel, 1'b0);
    step(3);

    // 4: release bounce with lcount=5
    a_data = 1'b0;
    step(5);
    chk("rb_press", a_press, 1'b1);
    step(5);
    a_data = 1'b1;
    step(2);
    chk("rb_level", a_level, 1'b1);
    chk("rb_rel", a_rel, 1'b0);
    a_data = 1'b0;
    step(1);
    chk("rb_back_rel", a_rel, 1'b0);
    chk("rb_back_long", a_long, 1'b0);
    step(4);
    chk("rb_long_early", a_long, 1'b0);
    step(1);
    chk("rb_long", a_long, 1'b1);
    step(1);
    a_data = 1'b1;
    step(4);
    chk("rb_rel_e3", a_rel, 1'b0);
    step(1);
    chk("rb_rel_e4", a_rel, 1'b1);
    chk("rb_rel_level", a_level, 1'b0);
    step(2);

    // 5: async reset in PRESS_PENDING, dcount=2
    a_data = 1'b0;
    step(3);
    #3;
    rst_a = 1'b0;
    #1;
    chk("rpp_level", a_level, 1'b0);
    chk("rpp_press", a_press, 1'b0);
    step(2);
    rst_a = 1'b1;
    step(4);
    chk("rpp_e3_press", a_press, 1'b0);
    step(1);
    chk("rpp_e4_press", a_press, 1'b1);
    chk("rpp_e4_level", a_level, 1'b1);
    step(2);
    // async reset while pressed: level drops, no release
    #3;
    rst_a = 1'b0;
    #1;
    chk("rp_level", a_level, 1'b0);
    chk("rp_rel", a_rel, 1'b0);
    step(2);
    rst_a = 1'b1;
    step(4);
    chk("rp_e3_press", a_press, 1'b0);
    step(1);
    chk("rp_e4_press", a_press, 1'b1);
    a_data = 1'b1;
    step(6);

    // 6: active-high polarity and bounces
    b_data = 1'b1;
    step(4);
    chk("pol_e3_press", b_press, 1'b0);
    step(1);
    chk("pol_e4_press", b_press, 1'b1);
    chk("pol_e4_level", b_level, 1'b1);
    for (int i = 0; i < 2; i++) begin
      b_data = 1'b0;
      step(1);
      b_data = 1'b1;
      step(1);
      chk("pol_bounce_level", b_level, 1'b1);
      chk("pol_bounce_rel", b_rel, 1'b0);
    end
    b_data = 1'b0;
    step(4);
    chk("pol_rel_e3", b_rel, 1'b0);
    step(1);
    chk("pol_rel_e4", b_rel, 1'b1);
    chk("pol_rel_level", b_level, 1'b0);
    step(2);

    chk("mutex", mutex_bad, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
